pattern_scan_ctrl: RTL

Sequencing controller for the serial pattern-match datapath: it captures a 6-bit target pattern, streams a framed serial bit sequence through a sliding window with a valid/ready handshake, and reports every position where the window equals the pattern. It owns the window's load/clear/shift enables and the match-qualification logic, so the raw comparator never reports a match before the window is full. It sits between a command source (start, pattern, frame length) and a serial bit source, and returns a match count and completion pulse.

---
 rtl/pattern_scan_pkg.sv | 7 +
 rtl/scan_window.sv | 15 +
 rtl/pattern_scan_ctrl.sv | 89 ++++++++
 3 files changed

// File: rtl/pattern_scan_pkg.sv
// pattern_scan_pkg: shared state encoding and default widths for the pattern scanner
package pattern_scan_pkg;
  localparam int DEF_PW = 6;
  localparam int DEF_LEN_W = 8;
  localparam int DEF_CNT_W = 8;
  typedef enum logic [2:0] {IDLE, LOAD, FILL, SCAN, DONE} state_t;
endpackage

// File: rtl/scan_window.sv
// scan_window: PW-bit serial-in shift register with sync clear, newest bit in the LSB
module scan_window #(
  parameter int PW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic          d,
  output logic [PW-1:0] q
);
  always_ff @(posedge clk)
    if (rst || clr) q <= '0;
    else if (en) q <= {q[PW-2:0], d};
endmodule

// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl: frames a serial bit stream through a sliding window and reports pattern hits
module pattern_scan_ctrl
  import pattern_scan_pkg::*;
#(
  parameter int PW    = DEF_PW,
  parameter int LEN_W = DEF_LEN_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PW-1:0]    pattern,
  input  logic [LEN_W-1:0] frame_len,
  input  logic             abort,
  input  logic             bit_valid,
  input  logic             bit_in,
  output logic             bit_ready,
  output logic             busy,
  output logic             match_pulse,
  output logic [LEN_W-1:0] match_pos,
  output logic [CNT_W-1:0] match_count,
  output logic             overflow,
  output logic             done
);
  state_t state, state_n;
  logic [PW-1:0] pat, win, next_win;
  logic [LEN_W-1:0] len, idx;
  logic hs, last, hit;
  // abort wins over a same-cycle handshake, so the offered bit is not consumed
  assign hs = bit_valid & bit_ready & ~abort;
  assign last = idx == len - LEN_W'(1);
  assign next_win = {win[PW-2:0], bit_in};
  // qualification starts at the bit that first fills the window
  assign hit = hs && idx >= LEN_W'(PW - 1) && next_win == pat;
  scan_window #(.PW(PW)) u_window (
    .clk(clk),
    .rst(rst),
    .clr(state == LOAD),
    .en (hs),
    .d  (bit_in),
    .q  (win)
  );
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = start ? LOAD : IDLE;
      LOAD: state_n = abort ? IDLE : (len == '0 ? DONE : FILL);
      FILL: state_n = abort ? IDLE : (hs && last ? DONE : (hs && idx == LEN_W'(PW - 1) ? SCAN : FILL));
      SCAN: state_n = abort ? IDLE : (hs && last ? DONE : SCAN);
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    bit_ready = state == FILL || state == SCAN;
    busy = state == LOAD || state == FILL || state == SCAN;
    done = state == DONE;
  end
  always_ff @(posedge clk)
    if (rst) begin
      pat <= '0;
      len <= '0;
      idx <= '0;
      match_pulse <= 1'b0;
      match_pos <= '0;
      match_count <= '0;
      overflow <= 1'b0;
    end else begin
      match_pulse <= hit;
      if (state == IDLE && start) begin
        pat <= pattern;
        len <= frame_len;
      end
      if (state == LOAD) begin
        idx <= '0;
        match_count <= '0;
        overflow <= 1'b0;
      end
      if (hs) idx <= idx + LEN_W'(1);
      if (hit) begin
        match_pos <= idx;
        if (match_count == '1) overflow <= 1'b1;
        else match_count <= match_count + CNT_W'(1);
      end
    end
endmodule
